// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   Size codes  : SZ_NONE/SZ_B/SZ_H/SZ_W, the LSU's d_we encoding.
//   Regions     : rgn_e, the result of decoding the LSU address.
//   MMIO offsets: word offsets d_addr[3:2] inside the 16-byte window.
//   STATUS bits : ST_MISALIGN, ST_UNMAPPED.
//   Helpers     : lane_en, lane_data, misaligned.
package dmem_pkg;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_B    = 2'b01;
   localparam logic [1:0] SZ_H    = 2'b10;
   localparam logic [1:0] SZ_W    = 2'b11;

   typedef enum logic [1:0] {
      RGN_RAM      = 2'd0,
      RGN_MMIO     = 2'd1,
      RGN_UNMAPPED = 2'd2
   } rgn_e;

   localparam logic [1:0] OFF_GPIO   = 2'd0;
   localparam logic [1:0] OFF_CYCLE  = 2'd1;
   localparam logic [1:0] OFF_FAULT  = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int ST_MISALIGN = 0;
   localparam int ST_UNMAPPED = 1;

   // Byte lanes touched by a store of size sz at byte offset a.
   function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] en;
      case (sz)
         SZ_B:    en = 4'b0001 << a;
         SZ_H:    en = a[1] ? 4'b1100 : 4'b0011;
         SZ_W:    en = 4'b1111;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

   // Store data replicated so every enabled lane sees the right bytes.
   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         SZ_B:    r = {4{d[7:0]}};
         SZ_H:    r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: LSU <-> data-memory controller bus.
//   d_addr    : byte address, valid every cycle       (LSU -> ctrl)
//   d_we      : store size code                       (LSU -> ctrl)
//   d_wr_data : right-aligned store data              (LSU -> ctrl)
//   d_rd_data : right-aligned read data, 1-cycle late (ctrl -> LSU)
interface dmem_if;
   logic [31:0] d_addr;
   logic [1:0]  d_we;
   logic [31:0] d_wr_data;
   logic [31:0] d_rd_data;

   modport master (output d_addr, output d_we, output d_wr_data, input d_rd_data);
   modport slave  (input d_addr, input d_we, input d_wr_data, output d_rd_data);
endinterface

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH_WORDS x 32 synchronous RAM, four byte enables,
// read-first registered read port. Contents are not reset so the
// block maps directly onto FPGA block RAM.
//   clk     : clock
//   addr_i  : word address
//   be_i    : byte-lane write enables
//   wdata_i : write data (already lane-replicated)
//   rdata_o : word at addr_i as it was before this edge's write
module dmem_sram #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic [3:0]                     be_i,
   input  logic [31:0]                    wdata_i,
   output logic [31:0]                    rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the load/store unit.
// Decodes RAM / MMIO / unmapped regions, turns size-coded stores into
// byte-lane writes, returns right-aligned read data one cycle after the
// address, and implements a 4-register MMIO window (GPIO, CYCLE,
// FAULT_ADDR, STATUS) with sticky fault reporting.
//   clk, rst  : clock, asynchronous active-high reset
//   lsu       : dmem_if slave (d_addr, d_we, d_wr_data, d_rd_data)
//   gpio_out  : GPIO register contents
//   fault_irq : OR of the sticky STATUS fault bits (registered)
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic     clk,
   input  logic     rst,
   dmem_if.slave    lsu,
   output logic [31:0] gpio_out,
   output logic        fault_irq
);

   localparam int          BYTE_AW   = $clog2(4 * DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

   rgn_e        rgn;
   logic        store;
   logic        mis;
   logic        fault_mis;
   logic        fault_unm;
   logic        wr_ok;
   logic [3:0]  be;
   logic [3:0]  ram_be;
   logic [3:0]  mmio_be;
   logic [31:0] wdata;
   logic [1:0]  off;

   logic [31:0] gpio_q, gpio_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic [1:0]  status_q, status_d;
   logic        fault_irq_q;
   rgn_e        rgn_q;
   logic [1:0]  boff_q;
   logic [31:0] mmio_rd_q, mmio_rd_d;
   logic [31:0] ram_rdata;
   logic [31:0] rd_word;

   always_comb begin
      if ({1'b0, lsu.d_addr} < RAM_BYTES)                 rgn = RGN_RAM;
      else if (lsu.d_addr[31:4] == MMIO_BASE[31:4])       rgn = RGN_MMIO;
      else                                                rgn = RGN_UNMAPPED;
   end

   assign store     = (lsu.d_we != SZ_NONE);
   assign mis       = misaligned(lsu.d_we, lsu.d_addr[1:0]);
   assign fault_mis = store && mis;
   assign fault_unm = store && (rgn == RGN_UNMAPPED);
   // A store arriving while reset is asserted must not reach the RAM,
   // which has no reset of its own.
   assign wr_ok     = store && !mis && !rst;
   assign be        = wr_ok ? lane_en(lsu.d_we, lsu.d_addr[1:0]) : 4'b0000;
   assign ram_be    = (rgn == RGN_RAM)  ? be : 4'b0000;
   assign mmio_be   = (rgn == RGN_MMIO) ? be : 4'b0000;
   assign wdata     = lane_data(lsu.d_we, lsu.d_wr_data);
   assign off       = lsu.d_addr[3:2];

   dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk     (clk),
      .addr_i  (lsu.d_addr[BYTE_AW-1:2]),
      .be_i    (ram_be),
      .wdata_i (wdata),
      .rdata_o (ram_rdata)
   );

   // Kept as a net so the counter can be preloaded from outside.
   assign cycle_d = cycle_q + 32'd1;

   always_comb begin
      gpio_d = gpio_q;
      if (off == OFF_GPIO) begin
         for (int i = 0; i < 4; i++) begin
            if (mmio_be[i]) gpio_d[8*i +: 8] = wdata[8*i +: 8];
         end
      end

      status_d = status_q;
      if ((off == OFF_STATUS) && mmio_be[0]) status_d = status_q & ~wdata[1:0];
      // Setting is applied after the W1C so a simultaneous fault wins.
      if (fault_mis) status_d[ST_MISALIGN] = 1'b1;
      if (fault_unm) status_d[ST_UNMAPPED] = 1'b1;

      fault_addr_d = (fault_mis || fault_unm) ? lsu.d_addr : fault_addr_q;

      case (off)
         OFF_GPIO:   mmio_rd_d = gpio_q;
         OFF_CYCLE:  mmio_rd_d = cycle_q;
         OFF_FAULT:  mmio_rd_d = fault_addr_q;
         default:    mmio_rd_d = {30'd0, status_q};
      endcase
   end

   // ---- register stage: control/state ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_q       <= '0;
         cycle_q      <= '0;
         fault_addr_q <= '0;
         status_q     <= '0;
         fault_irq_q  <= 1'b0;
         rgn_q        <= RGN_UNMAPPED;
      end else begin
         gpio_q       <= gpio_d;
         cycle_q      <= cycle_d;
         fault_addr_q <= fault_addr_d;
         status_q     <= status_d;
         fault_irq_q  <= |status_d;
         rgn_q        <= rgn;
      end
   end

   // ---- register stage: read data (qualified by rgn_q) ----
   always_ff @(posedge clk) begin
      boff_q    <= lsu.d_addr[1:0];
      mmio_rd_q <= mmio_rd_d;
   end

   always_comb begin
      case (rgn_q)
         RGN_RAM:  rd_word = ram_rdata;
         RGN_MMIO: rd_word = mmio_rd_q;
         default:  rd_word = '0;
      endcase
   end

   assign lsu.d_rd_data = rd_word >> {boff_q, 3'b000};
   assign gpio_out      = gpio_q;
   assign fault_irq     = fault_irq_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
   import dmem_pkg::*;

   localparam logic [31:0] M = 32'hFFFF_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] gpio_out;
   logic        fault_irq;

   dmem_if bus();

   dmem_ctrl #(.DEPTH_WORDS(1024), .MMIO_BASE(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .lsu       (bus),
      .gpio_out  (gpio_out),
      .fault_irq (fault_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  we;
      logic [31:0] wd;
      bit          chk;
      logic [31:0] rd;
      logic        irq;
      logic [31:0] gpio;
   } vec_t;

   vec_t vq[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [31:0] a, input logic [1:0] we, input logic [31:0] wd,
                               input bit c, input logic [31:0] rd, input logic irq,
                               input logic [31:0] g);
      vec_t v;
      v.addr = a; v.we = we; v.wd = wd; v.chk = c; v.rd = rd; v.irq = irq; v.gpio = g;
      vq.push_back(v);
   endfunction

   logic [31:0] v1, v2;

   initial begin
      // rd = read data for this vector's address (pre-store); irq/gpio after its edge
      add(32'h10,   SZ_W,    32'hDEADBEEF, 0, 32'h0,        0, 0);
      add(32'h10,   SZ_NONE, 0,            1, 32'hDEADBEEF, 0, 0);
      add(32'h10,   SZ_W,    32'h11223344, 1, 32'hDEADBEEF, 0, 0);
      add(32'h13,   SZ_B,    32'h000000AB, 1, 32'h00000011, 0, 0);
      add(32'h10,   SZ_NONE, 0,            1, 32'hAB223344, 0, 0);
      add(32'h13,   SZ_NONE, 0,            1, 32'h000000AB, 0, 0);
      add(32'h12,   SZ_H,    32'h0000CAFE, 1, 32'h0000AB22, 0, 0);
      add(32'h10,   SZ_NONE, 0,            1, 32'hCAFE3344, 0, 0);
      add(32'h12,   SZ_NONE, 0,            1, 32'h0000CAFE, 0, 0);
      add(32'h11,   SZ_H,    32'h00001234, 1, 32'h00CAFE33, 1, 0);
      add(32'h10,   SZ_NONE, 0,            1, 32'hCAFE3344, 1, 0);
      add(M+32'hC,  SZ_NONE, 0,            1, 32'h1,        1, 0);
      add(M+32'h8,  SZ_NONE, 0,            1, 32'h11,       1, 0);
      add(32'h80000000, SZ_W, 32'h55,      1, 32'h0,        1, 0);
      add(M+32'hC,  SZ_NONE, 0,            1, 32'h3,        1, 0);
      add(M+32'h8,  SZ_NONE, 0,            1, 32'h80000000, 1, 0);
      add(32'h80000000, SZ_NONE, 0,        1, 32'h0,        1, 0);
      add(M+32'hC,  SZ_W,    32'h3,        1, 32'h3,        0, 0);
      add(M+32'hC,  SZ_NONE, 0,            1, 32'h0,        0, 0);
      add(M+32'h8,  SZ_NONE, 0,            1, 32'h80000000, 0, 0);
      add(M,        SZ_W,    32'h5A5A5A5A, 1, 32'h0,        0, 32'h5A5A5A5A);
      add(M,        SZ_NONE, 0,            1, 32'h5A5A5A5A, 0, 32'h5A5A5A5A);
      add(M+32'h1,  SZ_B,    32'h000000C3, 1, 32'h005A5A5A, 0, 32'h5A5AC35A);
      add(M+32'h2,  SZ_H,    32'h00001234, 1, 32'h00005A5A, 0, 32'h1234C35A);
      add(32'hFFC,  SZ_W,    32'hA5A5A5A5, 0, 32'h0,        0, 32'h1234C35A);
      add(32'hFFC,  SZ_NONE, 0,            1, 32'hA5A5A5A5, 0, 32'h1234C35A);
      add(32'hFFF,  SZ_NONE, 0,            1, 32'h000000A5, 0, 32'h1234C35A);
      add(32'h1000, SZ_W,    32'h1,        1, 32'h0,        1, 32'h1234C35A);
      add(M+32'hC,  SZ_NONE, 0,            1, 32'h2,        1, 32'h1234C35A);
      add(M+32'hC,  SZ_B,    32'h02,       1, 32'h2,        0, 32'h1234C35A);
      add(32'h22,   SZ_W,    32'h0,        0, 32'h0,        1, 32'h1234C35A);
      add(M+32'h8,  SZ_NONE, 0,            1, 32'h22,       1, 32'h1234C35A);
      add(M+32'hC,  SZ_W,    32'h1,        1, 32'h1,        0, 32'h1234C35A);
      add(M+32'h8,  SZ_W,    32'hFFFFFFFF, 1, 32'h22,       0, 32'h1234C35A);
      add(M+32'h8,  SZ_NONE, 0,            1, 32'h22,       0, 32'h1234C35A);
      add(M,        SZ_W,    32'h5A5A5A5A, 1, 32'h1234C35A, 0, 32'h5A5A5A5A);

      bus.d_addr = 0; bus.d_we = SZ_NONE; bus.d_wr_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_gpio", gpio_out, 32'h0);
      chk("reset_irq", {31'd0, fault_irq}, 32'h0);
      chk("reset_rd", bus.d_rd_data, 32'h0);
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         bus.d_addr = vq[i].addr; bus.d_we = vq[i].we; bus.d_wr_data = vq[i].wd;
         @(posedge clk); #1;
         if (vq[i].chk) chk($sformatf("vec%0d_rd", i), bus.d_rd_data, vq[i].rd);
         chk($sformatf("vec%0d_irq", i), {31'd0, fault_irq}, {31'd0, vq[i].irq});
         chk($sformatf("vec%0d_gpio", i), gpio_out, vq[i].gpio);
      end

      // Reset in the middle of a word store
      @(negedge clk);
      rst = 1'b1; bus.d_addr = 32'h10; bus.d_we = SZ_W; bus.d_wr_data = 32'h77777777;
      #1;
      chk("rst_gpio_async", gpio_out, 32'h0);
      chk("rst_rd", bus.d_rd_data, 32'h0);
      @(negedge clk);
      rst = 1'b0; bus.d_we = SZ_NONE; bus.d_addr = M + 32'h4;
      #1;
      chk("rst_rd_after_release", bus.d_rd_data, 32'h0);
      @(posedge clk); #1;
      chk("rst_cycle_zero", bus.d_rd_data, 32'h0);
      @(negedge clk);
      bus.d_addr = 32'h10;
      @(posedge clk); #1;
      chk("rst_store_dropped", bus.d_rd_data, 32'hCAFE3344);
      chk("rst_irq", {31'd0, fault_irq}, 32'h0);

      // Cycle counter: 10 cycles apart
      @(negedge clk);
      bus.d_addr = M + 32'h4;
      @(posedge clk); #1;
      v1 = bus.d_rd_data;
      repeat (10) @(posedge clk);
      #1;
      v2 = bus.d_rd_data;
      chk("cycle_diff", v2 - v1, 32'd10);

      // Cycle counter wrap
      @(negedge clk);
      force dut.cycle_d = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.cycle_d;
      @(posedge clk); #1;
      chk("cycle_max", bus.d_rd_data, 32'hFFFFFFFF);
      @(posedge clk); #1;
      chk("cycle_wrap", bus.d_rd_data, 32'h0);

      // Store to CYCLE is ignored
      @(negedge clk);
      bus.d_we = SZ_W; bus.d_wr_data = 32'h12345678;
      @(posedge clk); #1;
      v1 = bus.d_rd_data;
      @(negedge clk);
      bus.d_we = SZ_NONE;
      @(posedge clk); #1;
      chk("cycle_ro", bus.d_rd_data, v1 + 32'd1);
      chk("cycle_ro_irq", {31'd0, fault_irq}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller behind the load/store unit. Accepts the LSU's per-cycle address, store-size code and unshifted store data, and generates byte-lane writes into a word-organised synchronous SRAM. Returns read data one cycle later, right-aligned to bit 0 so the LSU applies sign/zero extension directly. Also decodes a small MMIO window with a GPIO register, a free-running cycle counter and alignment/decode fault reporting.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words (power of two); RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window (16-byte aligned).
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- d_addr  in  32  byte address from the LSU, valid every cycle.
- d_we  in  2  store size code: 00 none, 01 byte, 10 half, 11 word.
- d_wr_data  in  32  store data, right-aligned (unshifted).
- d_rd_data  out  32  read data for the address presented in the previous cycle, right-aligned.
- gpio_out  out  32  GPIO register contents.
- fault_irq  out  1  OR of the sticky STATUS fault bits.

## Operation
- Region decode from d_addr:
  - RAM if d_addr < 4*DEPTH_WORDS.
  - MMIO if d_addr[31:4] == MMIO_BASE[31:4].
  - Otherwise UNMAPPED.
- Store lanes: byte → lane d_addr[1:0], data replicated ×4. Half → lanes {a1,a1+1} with a1 = d_addr[1]*2, data replicated ×2. Word → all lanes.
- Misaligned store (half with d_addr[0]=1; word with d_addr[1:0]≠0): no write. STATUS[0] set, FAULT_ADDR ← d_addr.
- UNMAPPED store: no write. STATUS[1] set, FAULT_ADDR ← d_addr.
- Loads are not size-checked; the controller does not know load size.
- Read path, every cycle with no side effects: RAM word d_addr[log2(4*DEPTH_WORDS)-1:2] (or the MMIO register) is captured at the edge, together with d_addr[1:0] and the region. Next cycle, d_rd_data = captured word >> (8*offset). UNMAPPED reads return 0.
- MMIO word offsets (d_addr[3:2]):
  - 0 GPIO_OUT: RW, byte-lane writes honoured.
  - 1 CYCLE: RO; 32-bit free-running, +1 every cycle, wraps to 0.
  - 2 FAULT_ADDR: RO.
  - 3 STATUS: bits[1:0]; a store writing lane 0 clears each bit whose data bit is 1 (W1C).
- Stores to RO registers are silently ignored and raise no fault.
- If a fault sets a STATUS bit in the same cycle that a W1C clears it, set wins.
- FAULT_ADDR records the most recent fault; it is not cleared by W1C.

## Timing
- Store: RAM and register write at the clk edge ending the cycle d_we≠0. A load of the same address in the following cycle returns the new data.
- Read latency is exactly 1 cycle. CYCLE reads return the counter value at the capturing edge.
- Read during a store in the same cycle returns pre-store (old) data (read-first).
- fault_irq is registered and asserts the cycle after the faulting store.
- Reset values:
  - gpio_out = 0; CYCLE = 0; FAULT_ADDR = 0; STATUS = 0; fault_irq = 0.
  - Captured region = UNMAPPED, so d_rd_data = 0 until the first post-reset edge.
  - RAM contents are not reset.
- Reset asserted mid-operation: any store in that cycle is dropped and all registers take their reset values immediately (async).

## Structure
- Shared package `dmem_pkg`:
  - size-code constants SZ_NONE/SZ_B/SZ_H/SZ_W, matching the LSU's d_we encoding;
  - region enum RGN_RAM/RGN_MMIO/RGN_UNMAPPED;
  - MMIO offset constants OFF_GPIO/OFF_CYCLE/OFF_FAULT/OFF_STATUS;
  - STATUS bit indices ST_MISALIGN=0, ST_UNMAPPED=1.
- One sub-module, `dmem_sram`: DEPTH_WORDS×32 synchronous RAM with 4 byte enables and read-first registered read. Enables the FPGA BRAM swap.

## Test plan
- Word store 0xDEADBEEF @0x10, then load @0x10 next cycle → d_rd_data 0xDEADBEEF one cycle after the load address.
- Byte store 0xAB @0x13 over 0x11223344 → load @0x10 gives 0xAB223344; load @0x13 gives 0x000000AB (right-aligned).
- Half store @0x12 with data 0x0000CAFE → word @0x10 reads 0xCAFExxxx with the low half unchanged. Half store @0x11 → no write, STATUS=01, FAULT_ADDR=0x11, fault_irq high the next cycle.
- Store @0x8000_0000 → STATUS[1] set, FAULT_ADDR=0x8000_0000. Load @0x8000_0000 → 0. Word store 0x3 to STATUS → 0, fault_irq low.
- Read CYCLE at two points 10 cycles apart → difference 10. Preload counter to 0xFFFFFFFF via force → reads 0 one cycle later (wrap). A store to CYCLE has no effect.
- Assert rst after GPIO_OUT=0x5A5A5A5A with a word store in flight → gpio_out 0 immediately, store dropped, d_rd_data 0 after release.
